// File: rtl/prj_definition.sv
// ---------------------------------------------------------------------------
// prj_definition : shared bus widths and responder state encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prj_definition;

    localparam int DATA_INDEX_LIMIT    = 31;
    localparam int ADDRESS_INDEX_LIMIT = 25;
    localparam int BUS_DATA_WIDTH      = DATA_INDEX_LIMIT + 1;
    localparam int BUS_ADDR_WIDTH      = ADDRESS_INDEX_LIMIT + 1;
    localparam int WR_COUNT_WIDTH      = 16;
    localparam int CNT_WIDTH           = 4;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2,
        RSP_DONE = 2'd3
    } rsp_state_t;

endpackage

`default_nettype wire

// File: rtl/da_vinci_resp_store.sv
// ---------------------------------------------------------------------------
// da_vinci_resp_store : single-port word array, sync write / async read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module da_vinci_resp_store
    import prj_definition::*;
#(
    parameter int    DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int    DEPTH_LOG2 = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

    // Contents deliberately survive reset.
    always @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/da_vinci_mem_responder.sv
// ---------------------------------------------------------------------------
// da_vinci_mem_responder : windowed memory responder with wait states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module da_vinci_mem_responder
    import prj_definition::*;
#(
    parameter int                    DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 26'h1000000,
    parameter int                    DEPTH_LOG2  = 4,
    parameter int                    WAIT_CYCLES = 2,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [ADDR_WIDTH-1:0]     ADDR,
    input  logic                      READ,
    input  logic                      WRITE,
    input  logic [DATA_WIDTH-1:0]     DATA_IN,
    output logic [DATA_WIDTH-1:0]     DATA_OUT,
    output logic                      READY,
    output logic                      ERR,
    output logic [WR_COUNT_WIDTH-1:0] WR_COUNT
);

    localparam logic [ADDR_WIDTH:0]    WINDOW_LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(2 ** DEPTH_LOG2);
    localparam logic [ADDR_WIDTH:0]    ADDR_SPACE   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH-1:0]   WAIT_LOAD    = CNT_WIDTH'(WAIT_CYCLES);
    localparam logic [WR_COUNT_WIDTH-1:0] COUNT_MAX = {WR_COUNT_WIDTH{1'b1}};

    generate
        if (WINDOW_LIMIT > ADDR_SPACE || DEPTH_LOG2 >= ADDR_WIDTH) begin : g_bad_window
            $error("da_vinci_mem_responder: window wraps past the address space");
        end
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("da_vinci_mem_responder: WAIT_CYCLES must be 0..15");
        end
    endgenerate

    rsp_state_t             state;
    rsp_state_t             state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   rd_q;
    logic                   wr_q;
    logic                   req;
    logic [ADDR_WIDTH-1:0]  rel_addr;
    logic                   in_window;
    logic                   bad_access;
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    assign req        = READ | WRITE;
    assign rel_addr   = addr_q - BASE_ADDR;
    // Below-base addresses wrap to large offsets, so both bounds are needed.
    assign in_window  = (addr_q >= BASE_ADDR) && (rel_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
    assign bad_access = (rd_q & wr_q) | ~in_window;
    assign mem_we     = (state == RSP_RESP) & wr_q & ~rd_q & in_window;

    da_vinci_resp_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_store (
        .clk   (CLK),
        .we    (mem_we),
        .addr  (rel_addr[DEPTH_LOG2-1:0]),
        .wdata (data_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RSP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RSP_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_CYCLES > 0) ? RSP_WAIT : RSP_RESP;
                end
            end
            RSP_WAIT: begin
                if (cnt <= CNT_WIDTH'(1)) begin
                    state_nxt = RSP_RESP;
                end
            end
            RSP_RESP: begin
                state_nxt = RSP_DONE;
            end
            RSP_DONE: begin
                // Holding off until the bus is idle stops a held request re-firing.
                if (!READ && !WRITE) begin
                    state_nxt = RSP_IDLE;
                end
            end
            default: begin
                state_nxt = RSP_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            DATA_OUT <= '0;
            READY    <= 1'b0;
            ERR      <= 1'b0;
            WR_COUNT <= '0;
        end else begin
            READY <= (state == RSP_RESP);
            ERR   <= (state == RSP_RESP) & bad_access;
            case (state)
                RSP_IDLE: begin
                    if (req) begin
                        addr_q <= ADDR;
                        data_q <= DATA_IN;
                        rd_q   <= READ;
                        wr_q   <= WRITE;
                        cnt    <= WAIT_LOAD;
                    end
                end
                RSP_WAIT: begin
                    cnt <= cnt - CNT_WIDTH'(1);
                end
                RSP_RESP: begin
                    if (rd_q) begin
                        DATA_OUT <= bad_access ? '0 : mem_rdata;
                    end
                    if (mem_we && WR_COUNT != COUNT_MAX) begin
                        WR_COUNT <= WR_COUNT + WR_COUNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_da_vinci_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_da_vinci_mem_responder : two responders (2 and 0 wait states) vs. a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_da_vinci_mem_responder;

    localparam logic [25:0] BASE = 26'h1000000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [25:0] addr_i [2];
    logic        rd_i   [2];
    logic        wr_i   [2];
    logic [31:0] din_i  [2];
    logic [31:0] dout_o [2];
    logic        rdy_o  [2];
    logic        err_o  [2];
    logic [15:0] cnt_o  [2];

    int errors = 0;
    int checks = 0;
    int ecount = 0;
    bit chk_en = 0;

    // Model state: index 0 = 2 wait states, index 1 = no wait states.
    int          target    [2];
    logic [31:0] cur_dout  [2];
    logic [15:0] cur_cnt   [2];
    logic [31:0] pend_dout [2];
    logic [15:0] pend_cnt  [2];
    bit          pend_err  [2];
    bit          pend_we   [2];
    logic [3:0]  pend_off  [2];
    logic [31:0] pend_data [2];
    logic [31:0] mem_m     [2][16];
    int          pulses    [2];

    da_vinci_mem_responder #(
        .DATA_WIDTH (32), .ADDR_WIDTH (26), .BASE_ADDR (26'h1000000),
        .DEPTH_LOG2 (4), .WAIT_CYCLES (2), .INIT_FILE ("")
    ) u_dut_w2 (
        .CLK (CLK), .RST (RST), .ADDR (addr_i[0]), .READ (rd_i[0]), .WRITE (wr_i[0]),
        .DATA_IN (din_i[0]), .DATA_OUT (dout_o[0]), .READY (rdy_o[0]), .ERR (err_o[0]),
        .WR_COUNT (cnt_o[0])
    );

    da_vinci_mem_responder #(
        .DATA_WIDTH (32), .ADDR_WIDTH (26), .BASE_ADDR (26'h1000000),
        .DEPTH_LOG2 (4), .WAIT_CYCLES (0), .INIT_FILE ("")
    ) u_dut_w0 (
        .CLK (CLK), .RST (RST), .ADDR (addr_i[1]), .READ (rd_i[1]), .WRITE (wr_i[1]),
        .DATA_IN (din_i[1]), .DATA_OUT (dout_o[1]), .READY (rdy_o[1]), .ERR (err_o[1]),
        .WR_COUNT (cnt_o[1])
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) ecount <= ecount + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: READY/ERR only on the predicted edge, DATA_OUT/WR_COUNT track the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                bit hit;
                hit = (ecount == target[d]);
                if (hit) begin
                    cur_dout[d] = pend_dout[d];
                    cur_cnt[d]  = pend_cnt[d];
                    if (pend_we[d]) mem_m[d][pend_off[d]] = pend_data[d];
                end
                check32($sformatf("ready[%0d]", d), 32'(rdy_o[d]), 32'(hit));
                check32($sformatf("err[%0d]", d), 32'(err_o[d]), hit ? 32'(pend_err[d]) : 32'd0);
                check32($sformatf("data_out[%0d]", d), dout_o[d], cur_dout[d]);
                check32($sformatf("wr_count[%0d]", d), 32'(cnt_o[d]), 32'(cur_cnt[d]));
                if (rdy_o[d]) pulses[d]++;
            end
        end
    end

    task automatic txn(input int d, input bit rd, input bit wr, input logic [25:0] a,
                       input logic [31:0] dat, input int hold,
                       output logic [31:0] got_dout, output logic got_err, output int got_lat);
        int         cap;
        bit         inwin;
        bit         bad;
        bit         seen;
        logic [3:0] off;
        @(negedge CLK);
        addr_i[d] = a;
        din_i[d]  = dat;
        rd_i[d]   = rd;
        wr_i[d]   = wr;
        cap   = ecount + 1;
        inwin = (a >= BASE) && (a <= BASE + 26'd15);
        bad   = (rd && wr) || !inwin;
        off   = 4'(a - BASE);
        pend_err[d]  = bad;
        pend_dout[d] = rd ? (bad ? 32'd0 : mem_m[d][off]) : cur_dout[d];
        pend_we[d]   = wr && !rd && inwin;
        pend_off[d]  = off;
        pend_data[d] = dat;
        pend_cnt[d]  = (pend_we[d] && cur_cnt[d] != 16'hFFFF) ? cur_cnt[d] + 16'd1 : cur_cnt[d];
        target[d]    = cap + ((d == 0) ? 2 : 0) + 1;
        got_dout = '0;
        got_err  = 1'b0;
        got_lat  = -1;
        seen     = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (rdy_o[d]) begin
                seen     = 1;
                got_dout = dout_o[d];
                got_err  = err_o[d];
                got_lat  = ecount - cap;
            end
        end
        check32("ready_seen", 32'(seen), 32'd1);
        repeat (hold) @(negedge CLK);
        rd_i[d] = 1'b0;
        wr_i[d] = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd;
        logic        ge;
        int          gl;
        int          p;
        logic [31:0] fib [16];
        for (int d = 0; d < 2; d++) begin
            addr_i[d] = '0; rd_i[d] = 1'b0; wr_i[d] = 1'b0; din_i[d] = '0;
            target[d] = -1; cur_dout[d] = '0; cur_cnt[d] = '0; pulses[d] = 0;
            pend_dout[d] = '0; pend_cnt[d] = '0; pend_err[d] = 0; pend_we[d] = 0;
            pend_off[d] = '0; pend_data[d] = '0;
            for (int k = 0; k < 16; k++) mem_m[d][k] = '0;
        end
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        chk_en = 1;

        // Write then read, 2 wait states.
        txn(0, 0, 1, BASE + 26'd5, 32'hDEADBEEF, 0, gd, ge, gl);
        check32("t2_wr_latency", 32'(gl), 32'd3);
        check32("t2_wr_err", 32'(ge), 32'd0);
        check32("t2_wr_count", 32'(cnt_o[0]), 32'd1);
        txn(0, 1, 0, BASE + 26'd5, 32'h0, 0, gd, ge, gl);
        check32("t2_rd_data", gd, 32'hDEADBEEF);
        check32("t2_rd_latency", 32'(gl), 32'd3);

        // Window edges.
        txn(0, 0, 1, BASE, 32'h0000A5A5, 0, gd, ge, gl);
        txn(0, 0, 1, BASE + 26'd15, 32'h5A5A0000, 0, gd, ge, gl);
        txn(0, 1, 0, BASE, 32'h0, 0, gd, ge, gl);
        check32("t3_rd_first", gd, 32'h0000A5A5);
        check32("t3_rd_first_err", 32'(ge), 32'd0);
        txn(0, 1, 0, BASE + 26'd15, 32'h0, 0, gd, ge, gl);
        check32("t3_rd_last", gd, 32'h5A5A0000);
        check32("t3_rd_last_err", 32'(ge), 32'd0);
        txn(0, 1, 0, 26'h0FFFFFF, 32'h0, 0, gd, ge, gl);
        check32("t3_below_err", 32'(ge), 32'd1);
        check32("t3_below_data", gd, 32'd0);
        txn(0, 0, 1, 26'h1000010, 32'h12345678, 0, gd, ge, gl);
        check32("t3_above_err", 32'(ge), 32'd1);
        check32("t3_above_count", 32'(cnt_o[0]), 32'd3);

        // READ and WRITE together.
        txn(0, 0, 1, BASE + 26'd2, 32'hC0FFEE00, 0, gd, ge, gl);
        txn(0, 1, 1, BASE + 26'd2, 32'hFFFFFFFF, 0, gd, ge, gl);
        check32("t4_both_err", 32'(ge), 32'd1);
        check32("t4_both_data", gd, 32'd0);
        txn(0, 1, 0, BASE + 26'd2, 32'h0, 0, gd, ge, gl);
        check32("t4_unchanged", gd, 32'hC0FFEE00);
        check32("t4_count", 32'(cnt_o[0]), 32'd4);

        // Request held for 10 cycles past READY.
        p = pulses[0];
        txn(0, 1, 0, BASE + 26'd5, 32'h0, 10, gd, ge, gl);
        check32("t5_single_pulse", 32'(pulses[0] - p), 32'd1);
        txn(0, 1, 0, BASE, 32'h0, 0, gd, ge, gl);
        check32("t5_next_latency", 32'(gl), 32'd3);

        // Fill every location so later random reads have known contents.
        for (int k = 0; k < 16; k++) txn(0, 0, 1, BASE + 26'(k), $urandom, 0, gd, ge, gl);
        txn(0, 0, 1, BASE + 26'd3, 32'hCAFEF00D, 0, gd, ge, gl);

        // Reset in the middle of the wait states of a write.
        p = pulses[0];
        @(negedge CLK);
        addr_i[0] = BASE + 26'd3; din_i[0] = 32'h11111111; wr_i[0] = 1'b1;
        repeat (2) @(negedge CLK);
        #2;
        RST = 1'b1;
        wr_i[0] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            target[d] = -1; cur_dout[d] = '0; cur_cnt[d] = '0;
        end
        @(negedge CLK);
        #2 RST = 1'b0;
        repeat (4) @(negedge CLK);
        check32("t1_no_pulse", 32'(pulses[0] - p), 32'd0);
        check32("t1_count_zero", 32'(cnt_o[0]), 32'd0);
        txn(0, 1, 0, BASE + 26'd3, 32'h0, 0, gd, ge, gl);
        check32("t1_prior_data", gd, 32'hCAFEF00D);

        // Fibonacci fill with no wait states.
        fib[0] = 32'd0;
        fib[1] = 32'd1;
        for (int k = 2; k < 16; k++) fib[k] = fib[k-1] + fib[k-2];
        for (int k = 0; k < 16; k++) begin
            txn(1, 0, 1, BASE + 26'(k), fib[k], 0, gd, ge, gl);
            check32("t6_wr_latency", 32'(gl), 32'd1);
        end
        check32("t6_count", 32'(cnt_o[1]), 32'd16);
        for (int k = 0; k < 16; k++) begin
            txn(1, 1, 0, BASE + 26'(k), 32'h0, 0, gd, ge, gl);
            check32("t6_readback", gd, fib[k]);
        end
        check32("t6_last_value", gd, 32'd610);

        // Random traffic on both responders.
        for (int n = 0; n < 80; n++) begin
            int          d;
            int          op;
            int          sel;
            bit          rd;
            bit          wr;
            logic [25:0] a;
            d   = int'($urandom % 2);
            op  = int'($urandom % 10);
            sel = int'($urandom % 10);
            rd  = (op < 4) || (op >= 8);
            wr  = (op >= 4);
            if (sel < 8)      a = BASE + 26'($urandom % 16);
            else if (sel == 8) a = BASE - 26'd1 - 26'($urandom % 4);
            else               a = BASE + 26'd16 + 26'($urandom % 4);
            txn(d, rd, wr, a, $urandom, int'($urandom % 4), gd, ge, gl);
            check32("rand_latency", 32'(gl), (d == 0) ? 32'd3 : 32'd1);
        end

        repeat (3) @(negedge CLK);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
